// File: rtl/usb_clk_pkg.sv
// Shared types and 48 MHz timing constants for the USB clock/reset sequencer.
package usb_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK   = 2'd0,
        HOLD        = 2'd1,
        PULLUP_WAIT = 2'd2,
        RUN         = 2'd3
    } seq_state_t;

    localparam int US_100 = 4800;
    localparam int MS_1   = 48000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/usb_sync_bit.sv
// Multi-flop synchroniser for one asynchronous input bit, cleared to 0 on reset.
module usb_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/usb_clk_reset_seq.sv
// Qualifies PLL lock, releases the USB core reset, then enables the D+ pull-up.
module usb_clk_reset_seq
    import usb_clk_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int STABLE_CYCLES       = US_100,
    parameter int RESET_HOLD_CYCLES   = 48,
    parameter int PULLUP_DELAY_CYCLES = MS_1
) (
    input  logic       clk48mhz,
    input  logic       rst_n,
    input  logic       clk_locked,
    output logic       sys_rst_n,
    output logic       usb_pullup_en,
    output logic       ready,
    output logic       lock_lost_pulse,
    output logic [7:0] lock_lost_cnt
);

    localparam int MAX_D =
        max3(STABLE_CYCLES, RESET_HOLD_CYCLES, PULLUP_DELAY_CYCLES);
    localparam int CNT_W = $clog2(MAX_D) + 1;

    localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULL_END   = CNT_W'(PULLUP_DELAY_CYCLES - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             lk;

    usb_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk48mhz),
        .rst_n(rst_n),
        .d    (clk_locked),
        .q    (lk)
    );

    always_ff @(posedge clk48mhz or negedge rst_n) begin
        if (!rst_n) begin
            state           <= WAIT_LOCK;
            cnt             <= '0;
            sys_rst_n       <= 1'b0;
            usb_pullup_en   <= 1'b0;
            ready           <= 1'b0;
            lock_lost_pulse <= 1'b0;
            lock_lost_cnt   <= '0;
        end else begin
            lock_lost_pulse <= 1'b0;
            if (state != WAIT_LOCK && !lk) begin
                // Loss beats any expiring count in the same cycle
                state           <= WAIT_LOCK;
                cnt             <= '0;
                sys_rst_n       <= 1'b0;
                usb_pullup_en   <= 1'b0;
                ready           <= 1'b0;
                lock_lost_pulse <= 1'b1;
                if (lock_lost_cnt != 8'hFF) begin
                    lock_lost_cnt <= lock_lost_cnt + 8'd1;
                end
            end else begin
                unique case (state)
                    WAIT_LOCK: begin
                        if (!lk) begin
                            cnt <= '0;
                        end else if (cnt == STABLE_END) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        if (cnt == HOLD_END) begin
                            state     <= PULLUP_WAIT;
                            cnt       <= '0;
                            sys_rst_n <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    PULLUP_WAIT: begin
                        if (cnt == PULL_END) begin
                            state         <= RUN;
                            usb_pullup_en <= 1'b1;
                            ready         <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        cnt <= cnt;
                    end
                    default: begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_clk_reset_seq.sv
// Randomised lock-waveform bench with a run-length reference model.
module tb_usb_clk_reset_seq;

    localparam int S = 8;
    localparam int H = 4;
    localparam int P = 16;

    logic       clk48mhz = 1'b0;
    logic       rst_n;
    logic       clk_locked;
    logic       sys_rst_n;
    logic       usb_pullup_en;
    logic       ready;
    logic       lock_lost_pulse;
    logic [7:0] lock_lost_cnt;

    int n_chk = 0;
    int n_pass = 0;

    // Model: lock history seen at edges, run length of lk highs, loss count
    logic p1, p2;
    int   run_len;
    int   m_cnt;
    logic m_pulse;
    int   edge_no;
    int   n_pulse;

    usb_clk_reset_seq #(
        .SYNC_STAGES(2),
        .STABLE_CYCLES(S),
        .RESET_HOLD_CYCLES(H),
        .PULLUP_DELAY_CYCLES(P)
    ) dut (
        .clk48mhz       (clk48mhz),
        .rst_n          (rst_n),
        .clk_locked     (clk_locked),
        .sys_rst_n      (sys_rst_n),
        .usb_pullup_en  (usb_pullup_en),
        .ready          (ready),
        .lock_lost_pulse(lock_lost_pulse),
        .lock_lost_cnt  (lock_lost_cnt)
    );

    always #5 clk48mhz = ~clk48mhz;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        p1 = 1'b0;
        p2 = 1'b0;
        run_len = 0;
        m_cnt = 0;
        m_pulse = 1'b0;
        edge_no = 0;
    endtask

    task automatic check_outs(input string tag);
        logic [11:0] obs, exp;
        obs = {sys_rst_n, usb_pullup_en, ready, lock_lost_pulse, lock_lost_cnt};
        exp = {run_len >= S + H, run_len >= S + H + P, run_len >= S + H + P,
               m_pulse, 8'(m_cnt)};
        check(tag, 32'(obs), 32'(exp));
    endtask

    task automatic step(input logic v);
        logic lkv;
        clk_locked = v;
        @(posedge clk48mhz);
        edge_no++;
        lkv = p2;
        p2 = p1;
        p1 = v;
        if (lkv) begin
            run_len++;
            m_pulse = 1'b0;
        end else begin
            m_pulse = (run_len >= S);
            if (m_pulse && m_cnt < 255) m_cnt++;
            run_len = 0;
        end
        #1;
        if (lock_lost_pulse) n_pulse++;
        check_outs("outs");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("reset");
        repeat (2) @(posedge clk48mhz);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_until_ready(input string tag);
        int k;
        k = 0;
        while (!ready && k < 60) begin
            step(1'b1);
            k++;
        end
        if (!ready) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int rise_at, pu_at, base, k, len;
        clk_locked = 1'b0;
        n_pulse = 0;
        #2;
        do_reset();

        // 1: lock high from the start
        rise_at = -1;
        pu_at = -1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1);
            if (sys_rst_n && rise_at < 0) rise_at = edge_no;
            if (usb_pullup_en && pu_at < 0) pu_at = edge_no;
        end
        check("rise_lat", 32'(rise_at), 32'(S + H + 2));
        check("pu_delay", 32'(pu_at - rise_at), 32'(P));
        check("ready1", 32'(ready), 1);
        check("cnt1", 32'(lock_lost_cnt), 0);

        // 2: glitch during qualification
        do_reset();
        repeat (5) step(1'b1);
        step(1'b0);
        base = edge_no;
        rise_at = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b1);
            if (sys_rst_n && rise_at < 0) rise_at = edge_no;
        end
        check("requal", 32'(rise_at - base), 32'(S + H + 2));
        check("cnt2", 32'(lock_lost_cnt), 0);

        // 3: one-cycle drop in RUN
        run_until_ready("s3");
        step(1'b0);
        step(1'b1);
        check("no_pulse_yet", 32'(lock_lost_pulse), 0);
        step(1'b1);
        check("pulse3", 32'(lock_lost_pulse), 1);
        check("rst3", 32'({sys_rst_n, usb_pullup_en}), 0);
        check("cnt3", 32'(lock_lost_cnt), 1);
        run_until_ready("s3b");

        // 4: drops in HOLD and PULLUP_WAIT
        do_reset();
        repeat (S + 4) step(1'b1);
        check("hold_rst", 32'(sys_rst_n), 0);
        step(1'b0);
        repeat (S + H + 6) step(1'b1);
        check("pw_state", 32'({sys_rst_n, usb_pullup_en}), 32'b10);
        step(1'b0);
        repeat (3) step(1'b1);
        check("cnt4", 32'(lock_lost_cnt), 2);

        // 5: saturation
        do_reset();
        n_pulse = 0;
        for (int i = 0; i < 260; i++) begin
            run_until_ready("s5");
            step(1'b0);
            repeat (3) step(1'b1);
        end
        check("sat", 32'(lock_lost_cnt), 255);
        check("pulses", 32'(n_pulse), 260);

        // 6: async reset in PULLUP_WAIT
        do_reset();
        repeat (S + H + 6) step(1'b1);
        check("pw6", 32'(sys_rst_n), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst",
              32'({sys_rst_n, usb_pullup_en, ready, lock_lost_pulse,
                   lock_lost_cnt}), 0);
        model_reset();
        repeat (2) @(posedge clk48mhz);
        #1 rst_n = 1'b1;
        rise_at = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            if (sys_rst_n && rise_at < 0) rise_at = edge_no;
        end
        check("restart", 32'(rise_at), 32'(S + H + 2));

        // Random lock waveforms
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            len = $urandom_range(1, 40);
            for (k = 0; k < len; k++) step(1'b1);
            len = $urandom_range(1, 3);
            for (k = 0; k < len; k++) step(1'b0);
        end
        repeat (4) step(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
